// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone classic single-transfer initiator.
// A read/write command taken on a valid/ready port becomes one Wishbone
// cycle. Its read data, or a write completion, comes back on a valid/ready
// response port. Every output is registered.
// Optional feature: define WB_CMD_MASTER_TIMEOUT_EN to add a bus watchdog.
// The watchdog aborts a cycle after TIMEOUT_CYCLES ack-less BUS cycles and
// reports the abort with rsp_err_o=1.
module wb_cmd_master #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [AW-1:0]     cmd_adr_i,
    input  logic [DW-1:0]     cmd_dat_i,
    input  logic [DW/8-1:0]   cmd_sel_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DW-1:0]     rsp_dat_o,
    output logic              rsp_err_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic [AW-1:0]     wb_adr_o,
    output logic [DW-1:0]     wb_dat_o,
    input  logic              wb_ack_i,
    input  logic [DW-1:0]     wb_dat_i,
    output logic              busy_o
);

    localparam int SW = DW / 8;

    typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_t;

    state_t            state_reg, state_next;
    logic              cmd_ready_reg, cmd_ready_next;
    logic              cyc_reg, cyc_next;
    logic              we_reg, we_next;
    logic [SW-1:0]     sel_reg, sel_next;
    logic [AW-1:0]     adr_reg, adr_next;
    logic [DW-1:0]     dat_reg, dat_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [DW-1:0]     rsp_dat_reg, rsp_dat_next;
    logic              busy_reg, busy_next;
    logic [DW-1:0]     rd_dat;
    logic              accept;
    logic              ack_hit;
    logic              to_hit;

    assign accept  = cmd_valid_i && cmd_ready_reg && (state_reg == ST_IDLE);
    assign ack_hit = (state_reg == ST_BUS) && wb_ack_i;

    // A write completion returns zero data, so each byte lane is masked by we.
    genvar gi;
    generate
        for (gi = 0; gi < SW; gi++) begin : g_lane
            assign rd_dat[gi*8 +: 8] = we_reg ? 8'h00 : wb_dat_i[gi*8 +: 8];
        end
    endgenerate

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt_reg;
    logic        rsp_err_reg, rsp_err_next;

    // An ack on the last allowed edge takes priority over the abort.
    assign to_hit = (state_reg == ST_BUS) && !wb_ack_i && (to_cnt_reg == TO_LAST);

    // Watchdog: cleared when a command enters BUS, counts each ack-less BUS cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            to_cnt_reg <= '0;
        end else if (accept) begin
            to_cnt_reg <= '0;
        end else if ((state_reg == ST_BUS) && !wb_ack_i) begin
            to_cnt_reg <= to_cnt_reg + 16'd1;
        end
    end

    assign rsp_err_o = rsp_err_reg;
`else
    assign to_hit    = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> BUS -> RESP -> IDLE, with no pipelining.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept)             state_next = ST_BUS;
            ST_BUS:  if (ack_hit || to_hit)  state_next = ST_RESP;
            ST_RESP: if (rsp_ready_i)        state_next = ST_IDLE;
            default:                         state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs. The bus fields hold after a cycle ends.
    always_comb begin
        cyc_next       = cyc_reg;
        we_next        = we_reg;
        sel_next       = sel_reg;
        adr_next       = adr_reg;
        dat_next       = dat_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_dat_next   = rsp_dat_reg;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        rsp_err_next   = rsp_err_reg;
`endif
        if (accept) begin
            cyc_next = 1'b1;
            we_next  = cmd_we_i;
            sel_next = cmd_sel_i;
            adr_next = cmd_adr_i;
            dat_next = cmd_dat_i;
        end
        if (ack_hit) begin
            cyc_next       = 1'b0;
            rsp_valid_next = 1'b1;
            rsp_dat_next   = rd_dat;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            rsp_err_next   = 1'b0;
`endif
        end else if (to_hit) begin
            cyc_next       = 1'b0;
            rsp_valid_next = 1'b1;
            rsp_dat_next   = '0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            rsp_err_next   = 1'b1;
`endif
        end
        if ((state_reg == ST_RESP) && rsp_ready_i) begin
            rsp_valid_next = 1'b0;
        end
        cmd_ready_next = (state_next == ST_IDLE);
        busy_next      = (state_next != ST_IDLE);
    end

    // Output registers. Reset clears everything except cmd_ready.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cmd_ready_reg <= 1'b1;
            cyc_reg       <= 1'b0;
            we_reg        <= 1'b0;
            sel_reg       <= '0;
            adr_reg       <= '0;
            dat_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_dat_reg   <= '0;
            busy_reg      <= 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            rsp_err_reg   <= 1'b0;
`endif
        end else begin
            cmd_ready_reg <= cmd_ready_next;
            cyc_reg       <= cyc_next;
            we_reg        <= we_next;
            sel_reg       <= sel_next;
            adr_reg       <= adr_next;
            dat_reg       <= dat_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_dat_reg   <= rsp_dat_next;
            busy_reg      <= busy_next;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
            rsp_err_reg   <= rsp_err_next;
`endif
        end
    end

    assign cmd_ready_o = cmd_ready_reg;
    assign wb_cyc_o    = cyc_reg;
    assign wb_stb_o    = cyc_reg;
    assign wb_we_o     = we_reg;
    assign wb_sel_o    = sel_reg;
    assign wb_adr_o    = adr_reg;
    assign wb_dat_o    = dat_reg;
    assign rsp_valid_o = rsp_valid_reg;
    assign rsp_dat_o   = rsp_dat_reg;
    assign busy_o      = busy_reg;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Testbench for wb_cmd_master: table of commands with expected responses,
// a scoreboard queue of expected responses, and hand-written sequences
// for response back-pressure, reset during BUS and the watchdog.
module tb_wb_cmd_master;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        wb_cyc, wb_stb, wb_we, wb_ack;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr, wb_dat_m, wb_dat_s;
    logic        busy;

    int          ack_at;
    int          bus_cnt;
    logic        force_ack;

    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    wb_cmd_master #(.AW(32), .DW(32), .TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
        .wb_sel_o(wb_sel), .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_m),
        .wb_ack_i(wb_ack), .wb_dat_i(wb_dat_s), .busy_o(busy)
    );

    // Slave model: ack during the ack_at-th cycle of a bus cycle (0 = never).
    assign wb_ack = force_ack || (wb_cyc && (ack_at != 0) && (bus_cnt == ack_at - 1));
    always @(posedge clk) bus_cnt <= wb_cyc ? bus_cnt + 1 : 0;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          ack_at;
        logic [31:0] sdat;
        int          hold;
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    vec_t vecs [8];
    int   n_vec;
    rsp_t sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Drive a command while IDLE, let it be accepted, check the bus fields.
    task automatic start_cmd(input vec_t v);
        cmd_we    = v.we;
        cmd_adr   = v.adr;
        cmd_dat   = v.dat;
        cmd_sel   = v.sel;
        ack_at    = v.ack_at;
        wb_dat_s  = v.sdat;
        cmd_valid = 1'b1;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        sb.push_back('{dat: v.exp_dat, err: v.exp_err});
        chk("cyc_start", 32'(wb_cyc), 32'd1);
        chk("stb_start", 32'(wb_stb), 32'd1);
        chk("wb_we", 32'(wb_we), 32'(v.we));
        chk("wb_adr", wb_adr, v.adr);
        chk("wb_dat", wb_dat_m, v.dat);
        chk("wb_sel", 32'(wb_sel), 32'(v.sel));
        chk("busy_bus", 32'(busy), 32'd1);
        chk("cmd_ready_bus", 32'(cmd_ready), 32'd0);
    endtask

    // Count the cycles cyc stays high, then expect a pending response.
    task automatic bus_phase(input vec_t v);
        int n = 0;
        bit ok = 1'b1;
        while (wb_cyc && n < 2000) begin
            n++;
            if (wb_stb !== wb_cyc || cmd_ready !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        chk("cyc_cycles", 32'(n), 32'(v.exp_cyc));
        chk("bus_stb_eq_cyc", 32'(ok), 32'd1);
        chk("rsp_valid_set", 32'(rsp_valid), 32'd1);
    endtask

    // Hold the response, check it is stable, then consume it against the scoreboard.
    task automatic rsp_phase(input vec_t v, input int hold, input bit pend_next, input vec_t nxt);
        logic [31:0] d0 = rsp_dat;
        logic        e0 = rsp_err;
        bit          stable = 1'b1;
        rsp_t        exp;
        if (pend_next) begin
            cmd_we = nxt.we; cmd_adr = nxt.adr; cmd_dat = nxt.dat; cmd_sel = nxt.sel;
            cmd_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_dat !== d0 || rsp_err !== e0 ||
                cmd_ready !== 1'b0 || wb_cyc !== 1'b0) stable = 1'b0;
        end
        chk("rsp_stable", 32'(stable), 32'd1);
        rsp_ready = 1'b1;
        chk("rsp_valid_hs", 32'(rsp_valid), 32'd1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
            exp = sb.pop_front();
            chk("rsp_dat", rsp_dat, exp.dat);
            chk("rsp_err", 32'(rsp_err), 32'(exp.err));
        end
        $display("txn we=%0d adr=0x%08h rsp_dat=0x%08h err=%0d hold=%0d",
                 v.we, v.adr, rsp_dat, rsp_err, hold);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_clr", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);
        if (pend_next) chk("no_accept_at_hs", 32'(wb_cyc), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t none;
        vec_t rd;
        none = '{we: 1'b0, adr: 32'h0, dat: 32'h0, sel: 4'h0, ack_at: 0, sdat: 32'h0,
                 hold: 0, exp_dat: 32'h0, exp_err: 1'b0, exp_cyc: 0};
        //            we    adr            dat            sel   ack sdat           hold  exp_dat        err   cyc
        vecs[0] = '{1'b1, 32'h2100_0000, 32'h0000_0001, 4'hF, 2, 32'h0000_0000, 0, 32'h0000_0000, 1'b0, 2};
        vecs[1] = '{1'b0, 32'h2100_0000, 32'h0000_0000, 4'hF, 2, 32'h0000_0003, 5, 32'h0000_0003, 1'b0, 2};
        vecs[2] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 1, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0, 1};
        vecs[3] = '{1'b1, 32'h0000_0004, 32'hA5A5_5A5A, 4'h3, 1, 32'hFFFF_FFFF, 2, 32'h0000_0000, 1'b0, 1};
        vecs[4] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 4'hF, 4, 32'h1234_5678, 1, 32'h1234_5678, 1'b0, 4};
        n_vec = 5;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        vecs[5] = '{1'b0, 32'h0000_000C, 32'h0000_0000, 4'hF, 0, 32'h5555_AAAA, 1, 32'h0000_0000, 1'b1, TO};
        vecs[6] = '{1'b1, 32'h0000_0020, 32'h0000_00FF, 4'h1, 0, 32'h5555_AAAA, 0, 32'h0000_0000, 1'b1, TO};
        vecs[7] = '{1'b0, 32'h0000_0024, 32'h0000_0000, 4'hF, 3, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 1'b0, 3};
        n_vec = 8;
`endif

        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        cmd_sel = '0; rsp_ready = 1'b0; wb_dat_s = '0; ack_at = 0; force_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_cyc", 32'(wb_cyc), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_dat", rsp_dat, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_wb_adr", wb_adr, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < n_vec; i++) begin
            start_cmd(vecs[i]);
            bus_phase(vecs[i]);
            rsp_phase(vecs[i], vecs[i].hold, 1'b0, none);
            chk("wb_adr_kept", wb_adr, vecs[i].adr);
            chk("wb_we_kept", 32'(wb_we), 32'(vecs[i].we));
        end

        // Back-pressure with a command already waiting: accepted one cycle after the handshake.
        start_cmd(vecs[1]);
        bus_phase(vecs[1]);
        rsp_phase(vecs[1], 5, 1'b1, vecs[0]);
        start_cmd(vecs[0]);
        bus_phase(vecs[0]);
        rsp_phase(vecs[0], 0, 1'b0, none);

        // Reset during BUS of a read from a slave that never acks.
        rd = vecs[1];
        rd.ack_at = 0;
        start_cmd(rd);
`ifndef WB_CMD_MASTER_TIMEOUT_EN
        begin
            int hi = 0;
            for (int i = 0; i < 1000; i++) begin
                if (wb_cyc === 1'b1) hi++;
                @(negedge clk);
            end
            chk("no_timeout_cyc_1000", 32'(hi), 32'd1000);
        end
`else
        @(negedge clk);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("midrst_cyc", 32'(wb_cyc), 32'd0);
        chk("midrst_stb", 32'(wb_stb), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("late_ack_cyc", 32'(wb_cyc), 32'd0);
        chk("late_ack_busy", 32'(busy), 32'd0);
        $display("txn reset during BUS adr=0x%08h", rd.adr);

        // The machine must still work after the reset.
        start_cmd(vecs[2]);
        bus_phase(vecs[2]);
        rsp_phase(vecs[2], 0, 1'b0, none);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
